// File: rtl/regfile_write_arbiter.sv
// Round-robin write-port arbiter for the 32 x 32-bit register bank, with a one-cycle registered issue stage.
// Optional same-cycle read bypass of the issuing write is enabled by defining REGFILE_WR_BYPASS_EN.
module regfile_write_arbiter #(
  parameter int NUM_REGS    = 32,
  parameter int ADDR_W      = $clog2(NUM_REGS),
  parameter int DATA_W      = 32,
  parameter bit ZERO_REG_RO = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                r0_valid,
  input  logic [ADDR_W-1:0]   r0_addr,
  input  logic [DATA_W-1:0]   r0_data,
  output logic                r0_ready,
  input  logic                r1_valid,
  input  logic [ADDR_W-1:0]   r1_addr,
  input  logic [DATA_W-1:0]   r1_data,
  output logic                r1_ready,
  input  logic                freeze,
`ifdef REGFILE_WR_BYPASS_EN
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic                rd_hit,
  output logic [DATA_W-1:0]   rd_fwd_data,
`endif
  output logic                wr_en,
  output logic [NUM_REGS-1:0] wr_sel,
  output logic [DATA_W-1:0]   wr_data,
  output logic                last_grant,
  output logic [CNT_W-1:0]    conflict_cnt
);

  localparam logic [NUM_REGS-1:0] SEL_ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};

  logic                wr_en_q, wr_en_d;
  logic [NUM_REGS-1:0] wr_sel_q, wr_sel_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                last_grant_q, last_grant_d;
  logic [CNT_W-1:0]    conflict_cnt_q, conflict_cnt_d;
  logic                acc0, acc1;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_data;
`ifdef REGFILE_WR_BYPASS_EN
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
`endif

  // Contested cycles go to the requester that did not win last; reset forces both readys low.
  always_comb begin
    r0_ready = 1'b0;
    r1_ready = 1'b0;
    if (reset && !freeze) begin
      if (r0_valid && r1_valid) begin
        r0_ready = last_grant_q;
        r1_ready = !last_grant_q;
      end else begin
        r0_ready = r0_valid;
        r1_ready = r1_valid;
      end
    end
  end

  always_comb begin
    acc0           = r0_valid && r0_ready;
    acc1           = r1_valid && r1_ready;
    win_addr       = acc1 ? r1_addr : r0_addr;
    win_data       = acc1 ? r1_data : r0_data;
    wr_en_d        = 1'b0;
    wr_sel_d       = '0;
    wr_data_d      = wr_data_q;
    last_grant_d   = last_grant_q;
    conflict_cnt_d = conflict_cnt_q;
`ifdef REGFILE_WR_BYPASS_EN
    wr_addr_d      = wr_addr_q;
`endif
    if (acc0 || acc1) begin
      last_grant_d = acc1;
      // A write to r0 is consumed here but never reaches the bank.
      if (!(ZERO_REG_RO && (win_addr == '0))) begin
        wr_en_d   = 1'b1;
        wr_sel_d  = SEL_ONE << win_addr;
        wr_data_d = win_data;
`ifdef REGFILE_WR_BYPASS_EN
        wr_addr_d = win_addr;
`endif
      end
    end
    if (r0_valid && r1_valid && (conflict_cnt_q != '1)) begin
      conflict_cnt_d = conflict_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en_q        <= 1'b0;
      wr_sel_q       <= '0;
      wr_data_q      <= '0;
      last_grant_q   <= 1'b1;
      conflict_cnt_q <= '0;
`ifdef REGFILE_WR_BYPASS_EN
      wr_addr_q      <= '0;
`endif
    end else begin
      wr_en_q        <= wr_en_d;
      wr_sel_q       <= wr_sel_d;
      wr_data_q      <= wr_data_d;
      last_grant_q   <= last_grant_d;
      conflict_cnt_q <= conflict_cnt_d;
`ifdef REGFILE_WR_BYPASS_EN
      wr_addr_q      <= wr_addr_d;
`endif
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_sel       = wr_sel_q;
  assign wr_data      = wr_data_q;
  assign last_grant   = last_grant_q;
  assign conflict_cnt = conflict_cnt_q;

`ifdef REGFILE_WR_BYPASS_EN
  assign rd_hit      = wr_en_q && (rd_addr == wr_addr_q);
  assign rd_fwd_data = rd_hit ? wr_data_q : '0;
`endif

  // Requesters must hold their write until it is accepted.
  r0_hold_a: assert property (@(posedge clk) disable iff (!reset)
    (r0_valid && !r0_ready) |=> r0_valid);
  r1_hold_a: assert property (@(posedge clk) disable iff (!reset)
    (r1_valid && !r1_ready) |=> r1_valid);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter (CNT_W narrowed to 4 to reach saturation quickly).
module tb_regfile_write_arbiter;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int CNT_W    = 4;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                r0_valid = 1'b0;
  logic [ADDR_W-1:0]   r0_addr = '0;
  logic [DATA_W-1:0]   r0_data = '0;
  logic                r0_ready;
  logic                r1_valid = 1'b0;
  logic [ADDR_W-1:0]   r1_addr = '0;
  logic [DATA_W-1:0]   r1_data = '0;
  logic                r1_ready;
  logic                freeze = 1'b0;
  logic                wr_en;
  logic [NUM_REGS-1:0] wr_sel;
  logic [DATA_W-1:0]   wr_data;
  logic                last_grant;
  logic [CNT_W-1:0]    conflict_cnt;
`ifdef REGFILE_WR_BYPASS_EN
  logic [ADDR_W-1:0]   rd_addr = '0;
  logic                rd_hit;
  logic [DATA_W-1:0]   rd_fwd_data;
`endif

  int errors = 0;
  int checks = 0;

  regfile_write_arbiter #(
    .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ZERO_REG_RO(1'b1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_data(r0_data), .r0_ready(r0_ready),
    .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_data(r1_data), .r1_ready(r1_ready),
    .freeze(freeze),
`ifdef REGFILE_WR_BYPASS_EN
    .rd_addr(rd_addr), .rd_hit(rd_hit), .rd_fwd_data(rd_fwd_data),
`endif
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .last_grant(last_grant), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    r0_valid = 1'b0; r1_valid = 1'b0; freeze = 1'b0;
    r0_addr = '0; r1_addr = '0; r0_data = '0; r1_data = '0;
    repeat (2) tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    r0_valid = 1'b1; r1_valid = 1'b1;
    repeat (2) tick();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_en got=%0b exp=0", wr_en); end
    checks++; if (wr_sel !== '0) begin errors++; $display("[TB] FAIL reset_wr_sel got=%h exp=0", wr_sel); end
    checks++; if (wr_data !== '0) begin errors++; $display("[TB] FAIL reset_wr_data got=%h exp=0", wr_data); end
    checks++; if (last_grant !== 1'b1) begin errors++; $display("[TB] FAIL reset_last_grant got=%0b exp=1", last_grant); end
    checks++; if (conflict_cnt !== '0) begin errors++; $display("[TB] FAIL reset_conflict_cnt got=%0d exp=0", conflict_cnt); end
    checks++; if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_readys got=%0b%0b exp=00", r0_ready, r1_ready); end
    r0_valid = 1'b0; r1_valid = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_single_write();
    do_reset();
    r0_valid = 1'b1; r0_addr = 5'd3; r0_data = 32'hDEADBEEF;
    #1;
    checks++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin errors++; $display("[TB] FAIL single_ready got=%0b%0b exp=10", r0_ready, r1_ready); end
    tick();
    r0_valid = 1'b0;
    checks++; if (wr_en !== 1'b1) begin errors++; $display("[TB] FAIL single_wr_en got=%0b exp=1", wr_en); end
    checks++; if (wr_sel !== 32'h0000_0008) begin errors++; $display("[TB] FAIL single_wr_sel got=%h exp=00000008", wr_sel); end
    checks++; if (wr_data !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL single_wr_data got=%h exp=deadbeef", wr_data); end
    checks++; if (last_grant !== 1'b0) begin errors++; $display("[TB] FAIL single_last_grant got=%0b exp=0", last_grant); end
    tick();
    checks++; if (wr_en !== 1'b0 || wr_sel !== '0) begin errors++; $display("[TB] FAIL idle_after_write got en=%0b sel=%h exp en=0 sel=0", wr_en, wr_sel); end
    checks++; if (wr_data !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL idle_data_hold got=%h exp=deadbeef", wr_data); end
  endtask

  task automatic test_contest();
    do_reset();
    r0_valid = 1'b1; r0_addr = 5'd1; r0_data = 32'h1111_0001;
    r1_valid = 1'b1; r1_addr = 5'd2; r1_data = 32'h2222_0002;
    #1;
    checks++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin errors++; $display("[TB] FAIL contest_first_ready got=%0b%0b exp=10", r0_ready, r1_ready); end
    tick();
    r0_valid = 1'b0;
    #1;
    checks++; if (wr_sel !== 32'h2 || wr_data !== 32'h1111_0001) begin errors++; $display("[TB] FAIL contest_first_issue got sel=%h data=%h exp sel=2 data=11110001", wr_sel, wr_data); end
    checks++; if (r1_ready !== 1'b1) begin errors++; $display("[TB] FAIL contest_second_ready got=%0b exp=1", r1_ready); end
    tick();
    r1_valid = 1'b0;
    checks++; if (wr_sel !== 32'h4 || wr_data !== 32'h2222_0002) begin errors++; $display("[TB] FAIL contest_second_issue got sel=%h data=%h exp sel=4 data=22220002", wr_sel, wr_data); end
    checks++; if (conflict_cnt !== 4'd1) begin errors++; $display("[TB] FAIL contest_conflict_cnt got=%0d exp=1", conflict_cnt); end
    checks++; if (last_grant !== 1'b1) begin errors++; $display("[TB] FAIL contest_last_grant got=%0b exp=1", last_grant); end
  endtask

  task automatic test_back_to_back();
    logic exp0;
    logic [NUM_REGS-1:0] exp_sel;
    do_reset();
    r0_valid = 1'b1; r0_addr = 5'd5; r0_data = 32'hA0A0_0005;
    r1_valid = 1'b1; r1_addr = 5'd6; r1_data = 32'hB0B0_0006;
    for (int k = 0; k < 6; k++) begin
      #1;
      exp0 = ((k % 2) == 0);
      checks++; if (r0_ready !== exp0 || r1_ready !== !exp0) begin errors++; $display("[TB] FAIL b2b_grant cycle=%0d got=%0b%0b exp=%0b%0b", k, r0_ready, r1_ready, exp0, !exp0); end
      tick();
      exp_sel = exp0 ? 32'h20 : 32'h40;
      checks++; if (wr_en !== 1'b1 || wr_sel !== exp_sel) begin errors++; $display("[TB] FAIL b2b_issue cycle=%0d got en=%0b sel=%h exp en=1 sel=%h", k, wr_en, wr_sel, exp_sel); end
    end
    r1_valid = 1'b0;
    #1;
    checks++; if (r0_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_tail_ready got=%0b exp=1", r0_ready); end
    tick();
    r0_valid = 1'b0;
    checks++; if (conflict_cnt !== 4'd6) begin errors++; $display("[TB] FAIL b2b_conflict_cnt got=%0d exp=6", conflict_cnt); end
  endtask

  task automatic test_saturate();
    do_reset();
    r0_valid = 1'b1; r0_addr = 5'd8;  r0_data = 32'h0000_0008;
    r1_valid = 1'b1; r1_addr = 5'd9;  r1_data = 32'h0000_0009;
    repeat (17) tick();
    r0_valid = 1'b0;
    tick();
    r1_valid = 1'b0;
    checks++; if (conflict_cnt !== 4'hF) begin errors++; $display("[TB] FAIL saturate_conflict_cnt got=%0d exp=15", conflict_cnt); end
    tick();
    checks++; if (conflict_cnt !== 4'hF) begin errors++; $display("[TB] FAIL saturate_hold got=%0d exp=15", conflict_cnt); end
  endtask

  task automatic test_zero_reg();
    do_reset();
    r0_valid = 1'b1; r0_addr = 5'd2; r0_data = 32'h0000_00AA;
    tick();
    r0_valid = 1'b0;
    r1_valid = 1'b1; r1_addr = 5'd0; r1_data = 32'h0000_00BB;
    #1;
    checks++; if (r1_ready !== 1'b1) begin errors++; $display("[TB] FAIL zero_ready got=%0b exp=1", r1_ready); end
    tick();
    r1_valid = 1'b0;
    checks++; if (wr_en !== 1'b0 || wr_sel !== '0) begin errors++; $display("[TB] FAIL zero_suppressed got en=%0b sel=%h exp en=0 sel=0", wr_en, wr_sel); end
    checks++; if (last_grant !== 1'b1) begin errors++; $display("[TB] FAIL zero_last_grant got=%0b exp=1", last_grant); end
  endtask

  task automatic test_freeze();
    do_reset();
    r0_valid = 1'b1; r0_addr = 5'd9; r0_data = 32'hC0C0_0009;
    tick();
    freeze = 1'b1;
    r0_addr = 5'd10; r0_data = 32'hD0D0_000A;
    #1;
    checks++; if (wr_en !== 1'b1 || wr_sel !== 32'h200 || wr_data !== 32'hC0C0_0009) begin errors++; $display("[TB] FAIL freeze_staged got en=%0b sel=%h data=%h exp en=1 sel=200 data=c0c00009", wr_en, wr_sel, wr_data); end
    checks++; if (r0_ready !== 1'b0) begin errors++; $display("[TB] FAIL freeze_ready got=%0b exp=0", r0_ready); end
    tick();
    checks++; if (wr_en !== 1'b0 || r0_ready !== 1'b0) begin errors++; $display("[TB] FAIL freeze_hold got en=%0b ready=%0b exp en=0 ready=0", wr_en, r0_ready); end
    freeze = 1'b0;
    #1;
    checks++; if (r0_ready !== 1'b1) begin errors++; $display("[TB] FAIL unfreeze_ready got=%0b exp=1", r0_ready); end
    tick();
    r0_valid = 1'b0;
    checks++; if (wr_sel !== 32'h400 || wr_data !== 32'hD0D0_000A) begin errors++; $display("[TB] FAIL unfreeze_issue got sel=%h data=%h exp sel=400 data=d0d0000a", wr_sel, wr_data); end
  endtask

  task automatic test_reset_midway();
    do_reset();
    r0_valid = 1'b1; r0_addr = 5'd4; r0_data = 32'hE0E0_0004;
    tick();
    r0_addr = 5'd11; r0_data = 32'hF0F0_000B;
    r1_valid = 1'b1; r1_addr = 5'd12; r1_data = 32'h0C0C_000C;
    #1;
    reset = 1'b0;
    #1;
    checks++; if (wr_en !== 1'b0 || wr_sel !== '0 || wr_data !== '0) begin errors++; $display("[TB] FAIL async_reset got en=%0b sel=%h data=%h exp all 0", wr_en, wr_sel, wr_data); end
    checks++; if (last_grant !== 1'b1 || r0_ready !== 1'b0 || r1_ready !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_grant got lg=%0b rdy=%0b%0b exp lg=1 rdy=00", last_grant, r0_ready, r1_ready); end
    repeat (2) tick();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_no_write got=%0b exp=0", wr_en); end
    reset = 1'b1;
    #1;
    checks++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_priority got=%0b%0b exp=10", r0_ready, r1_ready); end
    tick();
    r0_valid = 1'b0;
    checks++; if (wr_sel !== 32'h800 || wr_data !== 32'hF0F0_000B) begin errors++; $display("[TB] FAIL post_reset_r0 got sel=%h data=%h exp sel=800 data=f0f0000b", wr_sel, wr_data); end
    tick();
    r1_valid = 1'b0;
    checks++; if (wr_sel !== 32'h1000 || wr_data !== 32'h0C0C_000C) begin errors++; $display("[TB] FAIL post_reset_r1 got sel=%h data=%h exp sel=1000 data=0c0c000c", wr_sel, wr_data); end
  endtask

`ifdef REGFILE_WR_BYPASS_EN
  task automatic test_bypass();
    do_reset();
    rd_addr = 5'd7;
    r1_valid = 1'b1; r1_addr = 5'd7; r1_data = 32'h7777_1234;
    tick();
    r1_valid = 1'b0;
    checks++; if (rd_hit !== 1'b1 || rd_fwd_data !== 32'h7777_1234) begin errors++; $display("[TB] FAIL bypass_hit got hit=%0b data=%h exp hit=1 data=77771234", rd_hit, rd_fwd_data); end
    rd_addr = 5'd8;
    #1;
    checks++; if (rd_hit !== 1'b0 || rd_fwd_data !== '0) begin errors++; $display("[TB] FAIL bypass_miss got hit=%0b data=%h exp hit=0 data=0", rd_hit, rd_fwd_data); end
  endtask
`endif

  initial begin
    $display("[TB] starting regfile_write_arbiter bench");
    test_reset();
    test_single_write();
    test_contest();
    test_back_to_back();
    test_saturate();
    test_zero_reg();
    test_freeze();
    test_reset_midway();
`ifdef REGFILE_WR_BYPASS_EN
    test_bypass();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 32 x 32-bit register bank between two writeback requesters: requester 0 (ALU writeback) and requester 1 (load writeback).
- Arbitrates round-robin and accepts one write per cycle via valid/ready.
- Drives the bank's data_in, write enable and one-hot register selector from a registered issue stage.
- Sits between the execute/memory writeback paths and the register bank.

Parameters:
- NUM_REGS, 32, number of registers in the bank; equals the width of wr_sel.
- ADDR_W, 5, register address width; clog2(NUM_REGS).
- DATA_W, 32, register data width.
- ZERO_REG_RO, 1, when 1, writes to address 0 are accepted but never issued (r0 reads as zero).
- CNT_W, 16, width of the conflict counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- r0_valid  in  1  requester 0 has a write pending.
- r0_addr  in  ADDR_W  requester 0 target register.
- r0_data  in  DATA_W  requester 0 write data.
- r0_ready  out  1  requester 0 write accepted this cycle.
- r1_valid  in  1  requester 1 has a write pending.
- r1_addr  in  ADDR_W  requester 1 target register.
- r1_data  in  DATA_W  requester 1 write data.
- r1_ready  out  1  requester 1 write accepted this cycle.
- freeze  in  1  blocks new acceptances (debug halt / pipeline flush).
- wr_en  out  1  write enable to the register bank.
- wr_sel  out  NUM_REGS  one-hot register selector to the bank.
- wr_data  out  DATA_W  data to the bank.
- last_grant  out  1  requester granted most recently.
- conflict_cnt  out  CNT_W  saturating count of cycles in which both requesters were valid.

Behaviour:
- Reset (reset low, asynchronous): wr_en=0, wr_sel=0, wr_data=0, last_grant=1 (so requester 0 has priority first), conflict_cnt=0, both readys 0. The staged write is dropped.
- Readys are combinational from valid, freeze and last_grant:
  - With freeze=1, both readys are 0.
  - Only one requester valid: that requester is ready.
  - Both valid: the requester other than last_grant is ready.
  - At most one ready is high per cycle.
- Accept = valid && ready. On accept, last_grant updates to the accepted requester. With no accept, last_grant holds.
- Requester rule: valid, addr and data stay stable until accepted. Dropping valid before acceptance is illegal (checked by assertion).
- Issue latency is 1 cycle. On an accept in cycle N, wr_en=1, wr_sel=1<<addr and wr_data=data are registered for cycle N+1. The bank commits at the rising edge ending cycle N+1.
- No accept in cycle N: in cycle N+1, wr_en=0 and wr_sel=0; wr_data holds its last value.
- ZERO_REG_RO=1 and accepted addr==0: the write is accepted (ready=1) but cycle N+1 has wr_en=0 and wr_sel=0.
- freeze does not cancel a write already staged; it still issues in the next cycle.
- conflict_cnt increments by 1 in every cycle where r0_valid && r1_valid, freeze included. It saturates at all-ones and does not wrap.
- Back-to-back operation: one write can be accepted every cycle, giving a sustained throughput of 1 write/cycle. A contested pair issues in order winner, loser in consecutive cycles.
- Reset asserted mid-operation: the pending staged write is lost. A requester holding valid is re-accepted after reset deasserts, with requester 0 given priority.

Optional Feature:
- Macro: REGFILE_WR_BYPASS_EN.
- Defined:
  - Adds input rd_addr [ADDR_W] and outputs rd_hit [1] and rd_fwd_data [DATA_W].
  - rd_hit = wr_en && (rd_addr == staged addr), combinational.
  - rd_fwd_data = wr_data when rd_hit is high, else 0.
  - This lets a same-cycle reader see the write being committed.
- Undefined: these ports and their logic are absent.

Test Plan:
- Reset release, r0_valid=1, addr=3, data=0xDEADBEEF → r0_ready=1 in cycle 0; in cycle 1, wr_en=1, wr_sel=0x00000008, wr_data=0xDEADBEEF.
- Both valid from reset (r0 addr=1, r1 addr=2), held until accepted → r0 accepted first, then r1. wr_sel goes 0x2 then 0x4 on consecutive cycles. conflict_cnt=1.
- Both requesters continuously valid for 6 cycles → grants alternate 0,1,0,1,0,1 and conflict_cnt=6.
- r1 write to addr 0 with ZERO_REG_RO=1 → r1_ready=1; next cycle wr_en=0, wr_sel=0.
- Write accepted in cycle N, freeze=1 asserted in cycle N+1 with r0_valid high → cycle N+1 still issues the staged write; r0_ready stays 0 until freeze drops.
- reset pulled low while a write is staged → wr_en=0 immediately (asynchronous); no write occurs. With REGFILE_WR_BYPASS_EN, a write to addr 7 with rd_addr=7 gives rd_hit=1 and rd_fwd_data equal to the written data.
